// File: rtl/eprisc_sysx_slave.sv
// sysX bus responder: oversampled bus decode to a 32-bit register strobe port.
// Define SYSX_SLAVE_AUTOINC_EN for burst transfers with address auto-increment.
module eprisc_sysx_slave #(
    parameter int pDeviceID   = 1,
    parameter int pSyncStages = 2
) (
    input  logic        iBoardClock,
    input  logic        iBoardReset,
    input  logic        iBusClock,
    input  logic [1:0]  iBusSelect,
    input  logic [7:0]  iBusMOSI,
    output logic [7:0]  oBusMISO,
    output logic        oBusMISOEnable,
    output logic        oBusInterrupt,
    output logic [6:0]  oRegAddress,
    output logic [31:0] oRegWriteData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [31:0] iRegReadData,
    input  logic        iDevInterrupt
);

`ifdef SYSX_SLAVE_AUTOINC_EN
    localparam bit cAutoInc = 1'b1;
`else
    localparam bit cAutoInc = 1'b0;
`endif

    typedef enum logic [2:0] {
        sIdle,
        sCmd,
        sRdReq,
        sRdCap,
        sRData,
        sWData,
        sWStrobe,
        sDone
    } state_t;

    state_t state;
    state_t stateNext;

    logic [pSyncStages-1:0]      clkSync;
    logic [pSyncStages-1:0][1:0] selSync;
    logic [pSyncStages-1:0][7:0] mosiSync;
    logic                        clkPrev;
    logic [1:0]                  byteCount;
    logic [31:0]                 rdShift;
    logic                        misoEn;

    logic       busClk;
    logic       rise;
    logic       fall;
    logic       selected;
    logic [7:0] mosi;
    logic       lastByte;

    assign busClk   = clkSync[pSyncStages-1];
    assign rise     = busClk & ~clkPrev;
    assign fall     = ~busClk & clkPrev;
    assign selected = (selSync[pSyncStages-1] == 2'(pDeviceID));
    assign mosi     = mosiSync[pSyncStages-1];
    assign lastByte = (byteCount == 2'd3);

    // Gate with selected so enable drops in the same cycle as the deselect.
    assign oBusMISOEnable = misoEn & selected;
    assign oRegRead       = (state == sRdReq);
    assign oRegWrite      = (state == sWStrobe);

    always_ff @(posedge iBoardClock or posedge iBoardReset) begin
        if (iBoardReset) begin
            clkSync  <= '0;
            selSync  <= '0;
            mosiSync <= '0;
            clkPrev  <= 1'b0;
        end else begin
            clkSync  <= {clkSync[pSyncStages-2:0], iBusClock};
            selSync  <= {selSync[pSyncStages-2:0], iBusSelect};
            mosiSync <= {mosiSync[pSyncStages-2:0], iBusMOSI};
            clkPrev  <= busClk;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            sIdle:    if (selected) stateNext = sCmd;
            sCmd:     if (rise) stateNext = mosi[7] ? sWData : sRdReq;
            sRdReq:   stateNext = sRdCap;
            sRdCap:   stateNext = sRData;
            sRData:   if (rise && lastByte) stateNext = cAutoInc ? sRdReq : sDone;
            sWData:   if (rise && lastByte) stateNext = sWStrobe;
            sWStrobe: stateNext = cAutoInc ? sWData : sDone;
            sDone:    stateNext = sDone;
        endcase
        // Deselect overrides any edge seen in the same cycle.
        if (!selected) stateNext = sIdle;
    end

    always_ff @(posedge iBoardClock or posedge iBoardReset) begin
        if (iBoardReset) begin
            state         <= sIdle;
            byteCount     <= 2'd0;
            rdShift       <= '0;
            misoEn        <= 1'b0;
            oBusMISO      <= 8'h00;
            oBusInterrupt <= 1'b0;
            oRegAddress   <= 7'h00;
            oRegWriteData <= '0;
        end else begin
            state         <= stateNext;
            oBusInterrupt <= iDevInterrupt;
            if (!selected) begin
                byteCount <= 2'd0;
                misoEn    <= 1'b0;
                oBusMISO  <= 8'h00;
            end else begin
                case (state)
                    sCmd: begin
                        byteCount <= 2'd0;
                        if (rise) oRegAddress <= mosi[6:0];
                    end
                    sRdCap: rdShift <= iRegReadData;
                    sRData: begin
                        if (fall) begin
                            oBusMISO <= rdShift[31:24];
                            rdShift  <= {rdShift[23:0], 8'h00};
                            misoEn   <= 1'b1;
                        end
                        // Two-bit counter wraps to zero after the fourth byte.
                        if (rise) begin
                            byteCount <= byteCount + 2'd1;
                            if (cAutoInc && lastByte)
                                oRegAddress <= oRegAddress + 7'd1;
                        end
                    end
                    sWData: begin
                        if (rise) begin
                            oRegWriteData <= {oRegWriteData[23:0], mosi};
                            byteCount     <= byteCount + 2'd1;
                        end
                    end
                    sWStrobe: begin
                        if (cAutoInc) oRegAddress <= oRegAddress + 7'd1;
                    end
                    sDone: if (fall) oBusMISO <= 8'hFF;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eprisc_sysx_slave.sv
// Bench for eprisc_sysx_slave: bus-master model, strobe scoreboard, vector table.
// Burst sequence expectations follow SYSX_SLAVE_AUTOINC_EN when defined.
module tb_eprisc_sysx_slave;

    localparam int cHalf = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busClk = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  mosi = 8'h00;
    logic [7:0]  miso;
    logic        misoEn;
    logic        busInt;
    logic [6:0]  regAddr;
    logic [31:0] regWData;
    logic        regWrite;
    logic        regRead;
    logic [31:0] rdData = 32'h0;
    logic        devInt = 1'b0;

    eprisc_sysx_slave #(.pDeviceID(1), .pSyncStages(2)) dut (
        .iBoardClock    (clk),
        .iBoardReset    (rst),
        .iBusClock      (busClk),
        .iBusSelect     (sel),
        .iBusMOSI       (mosi),
        .oBusMISO       (miso),
        .oBusMISOEnable (misoEn),
        .oBusInterrupt  (busInt),
        .oRegAddress    (regAddr),
        .oRegWriteData  (regWData),
        .oRegWrite      (regWrite),
        .oRegRead       (regRead),
        .iRegReadData   (rdData),
        .iDevInterrupt  (devInt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic        isWrite;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  cmd;
        logic [31:0] wd;
        int          nData;
        logic [31:0] rd;
        int          expKind;
        logic        expEn;
    } vec_t;

    ev_t  sb[$];
    int   nChecks = 0;
    int   nFails = 0;
    logic enSeen = 1'b0;
    logic [7:0] txBytes [10];
    logic [7:0] rxBytes [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (!rst) begin
            if (misoEn) enSeen = 1'b1;
            if (regWrite || regRead) begin
                if (sb.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected strobe: wr=%b rd=%b addr=%h, expected none",
                             regWrite, regRead, regAddr);
                end else begin
                    e = sb.pop_front();
                    check("strobe kind", {31'd0, regWrite}, {31'd0, e.isWrite});
                    check("strobe addr", {25'd0, regAddr}, {25'd0, e.addr});
                    if (e.isWrite) check("write data", regWData, e.data);
                end
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busByte(input logic [7:0] b, output logic [7:0] m);
        mosi = b;
        waitClk(cHalf);
        m = miso;
        busClk = 1'b1;
        waitClk(cHalf);
        busClk = 1'b0;
    endtask

    task automatic txn(input logic [1:0] s, input int n);
        sel = s;
        waitClk(cHalf);
        for (int i = 0; i < n; i++) busByte(txBytes[i], rxBytes[i]);
        waitClk(cHalf);
        sel = 2'd0;
        waitClk(cHalf);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd1, 8'h85, 32'hDEADBEEF, 4, 32'h0, 1, 1'b0};
        vecs[1] = '{2'd1, 8'h12, 32'h0, 5, 32'h01234567, 2, 1'b1};
        vecs[2] = '{2'd2, 8'h85, 32'hDEADBEEF, 4, 32'h0, 0, 1'b0};
        vecs[3] = '{2'd1, 8'h80, 32'h11220000, 2, 32'h0, 0, 1'b0};
        vecs[4] = '{2'd1, 8'h81, 32'hCAFEF00D, 4, 32'h0, 1, 1'b0};
        vecs[5] = '{2'd1, 8'h7F, 32'h0, 5, 32'h89ABCDEF, 2, 1'b1};
        vecs[6] = '{2'd3, 8'h02, 32'h0, 5, 32'h13572468, 0, 1'b0};

        waitClk(3);
        check("reset outputs", {19'd0, miso, misoEn, busInt, regAddr, regWrite, regRead},
              32'h0);
        check("reset wdata", regWData, 32'h0);
        rst = 1'b0;
        waitClk(4);

        devInt = 1'b1;
        #1 check("irq before edge", {31'd0, busInt}, 32'd0);
        @(posedge clk);
        #1 check("irq after edge", {31'd0, busInt}, 32'd1);
        devInt = 1'b0;
        waitClk(1);
        check("irq clear", {31'd0, busInt}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            enSeen = 1'b0;
            rdData = vecs[v].rd;
            if (vecs[v].expKind == 1) sb.push_back('{vecs[v].cmd[6:0], 1'b1, vecs[v].wd});
            if (vecs[v].expKind == 2) sb.push_back('{vecs[v].cmd[6:0], 1'b0, 32'h0});
            txBytes[0] = vecs[v].cmd;
            for (int j = 0; j < vecs[v].nData; j++)
                txBytes[j+1] = vecs[v].cmd[7] ? vecs[v].wd[31-8*j -: 8] : 8'h00;
            txn(vecs[v].sel, vecs[v].nData + 1);
            if (vecs[v].expKind == 2) begin
                for (int j = 1; j <= 4; j++)
                    check($sformatf("vec%0d miso%0d", v, j), {24'd0, rxBytes[j]},
                          {24'd0, vecs[v].rd[39-8*j -: 8]});
                check($sformatf("vec%0d miso ff", v), {24'd0, rxBytes[5]}, 32'hFF);
            end
            check($sformatf("vec%0d enable seen", v), {31'd0, enSeen}, {31'd0, vecs[v].expEn});
            check($sformatf("vec%0d sb drained", v), sb.size(), 32'd0);
        end

        // Reset in the middle of the read data phase.
        rdData = 32'hA5C35A3C;
        sb.push_back('{7'h00, 1'b0, 32'h0});
        sel = 2'd1;
        waitClk(cHalf);
        busByte(8'h00, rxBytes[0]);
        busByte(8'h00, rxBytes[1]);
        check("pre-reset miso1", {24'd0, rxBytes[1]}, 32'hA5);
        waitClk(6);
        check("pre-reset enable", {31'd0, misoEn}, 32'd1);
        check("pre-reset miso2", {24'd0, miso}, 32'hC3);
        rst = 1'b1;
        #1;
        check("mid-reset outputs", {19'd0, miso, misoEn, busInt, regAddr, regWrite, regRead},
              32'h0);
        check("mid-reset wdata", regWData, 32'h0);
        sel = 2'd0;
        waitClk(3);
        rst = 1'b0;
        waitClk(4);
        rdData = 32'h5A3CA5C3;
        sb.push_back('{7'h00, 1'b0, 32'h0});
        txBytes[0] = 8'h00;
        for (int j = 1; j <= 5; j++) txBytes[j] = 8'h00;
        txn(2'd1, 6);
        for (int j = 1; j <= 4; j++)
            check($sformatf("post-reset miso%0d", j), {24'd0, rxBytes[j]},
                  {24'd0, rdData[39-8*j -: 8]});
        check("post-reset miso ff", {24'd0, rxBytes[5]}, 32'hFF);

        // Eight data bytes at the top address.
        txBytes[0] = 8'hFF;
        for (int j = 0; j < 8; j++) txBytes[j+1] = 8'(8'h10 + 8'(j * 17));
        sb.push_back('{7'h7F, 1'b1, {txBytes[1], txBytes[2], txBytes[3], txBytes[4]}});
`ifdef SYSX_SLAVE_AUTOINC_EN
        sb.push_back('{7'h00, 1'b1, {txBytes[5], txBytes[6], txBytes[7], txBytes[8]}});
`endif
        txn(2'd1, 9);
        check("burst sb drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
